// File: rtl/led_seq.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq
//  Description : RGB LED pattern sequencer. Plays a 4-entry table of
//                {rgb, duration} steps paced by the clk_div strobe.
//                o_led only ever changes in the cycle after a strobe.
//                Optional 16-level PWM dimmer enabled by defining the macro
//                LED_SEQ_PWM_EN; without it i_bright is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq #(
    parameter int TICK_STB = 469,          // strobes per duration tick, >= 2
    parameter int CLK_FREQ = 48_000_000    // informational only
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_wr,
    input  logic [1:0]  i_waddr,
    input  logic [10:0] i_wdata,
    input  logic [1:0]  i_last,
    input  logic        i_loop,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [3:0]  i_bright,
    output logic [2:0]  o_led,
    output logic        o_busy,
    output logic [1:0]  o_step,
    output logic        o_done
);

    // Tick counter is sized to hold 0 .. TICK_STB-1.
    localparam int            c_TW       = (TICK_STB > 1) ? $clog2(TICK_STB) : 1;
    localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICK_STB - 1);
    localparam logic [c_TW-1:0] c_TICK_ONE = c_TW'(1);

    // The clock frequency is kept for documentation of the tick period.
    localparam int c_unused_clk_freq = CLK_FREQ;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t          r_state;
    logic [10:0]     r_table [0:3];
    logic [1:0]      r_step;
    logic [c_TW-1:0] r_tick_cnt;
    logic [7:0]      r_dur_cnt;
    logic [2:0]      r_rgb;        // colour latched on step entry
    logic [2:0]      r_led;
    logic            r_busy;
    logic            r_done;

    logic            w_tick;
    logic [1:0]      w_next_step;
    logic [2:0]      w_pwm_mask;
    logic [2:0]      w_led_next;

    // A duration tick fires on the strobe that completes TICK_STB strobes.
    assign w_tick      = i_stb && (r_tick_cnt == c_TICK_MAX);
    assign w_next_step = r_step + 2'd1;

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running PWM phase, advanced by every strobe in every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_cnt <= 4'd0;
        end else if (i_stb) begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    // Channel may light only while the phase is at or below the brightness.
    assign w_pwm_mask = {3{r_pwm_cnt <= i_bright}};
`else
    // No dimmer: full duty, brightness input is deliberately ignored.
    assign w_pwm_mask = 3'b111;
    logic w_unused_bright;
    assign w_unused_bright = ^i_bright;
`endif

    // The LED level is computed from the state as it stands at the strobe,
    // so leaving PLAY blanks the LED at the next strobe.
    assign w_led_next = (r_state == S_PLAY) ? (r_rgb & w_pwm_mask) : 3'b000;

    // Step table storage; writes never stall and never affect a step in
    // progress because the colour and duration are copied on entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_table[i] <= 11'd0;
            end
        end else if (i_wr) begin
            r_table[i_waddr] <= i_wdata;
        end
    end

    // Playback state machine: step sequencing, tick and duration counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_step     <= 2'd0;
            r_tick_cnt <= '0;
            r_dur_cnt  <= 8'd0;
            r_rgb      <= 3'b000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Stop has priority over a simultaneous start.
                    if (i_start && !i_stop) begin
                        r_state    <= S_PLAY;
                        r_busy     <= 1'b1;
                        r_step     <= 2'd0;
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= r_table[0][7:0];
                        r_rgb      <= r_table[0][10:8];
                    end
                end
                S_PLAY: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_start) begin
                        // Restart outranks any step end in the same cycle,
                        // which also suppresses a coincident done pulse.
                        r_step     <= 2'd0;
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= r_table[0][7:0];
                        r_rgb      <= r_table[0][10:8];
                    end else if (i_stb) begin
                        if (w_tick) begin
                            r_tick_cnt <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                        end
                        if (w_tick) begin
                            if (r_dur_cnt != 8'd0) begin
                                r_dur_cnt <= r_dur_cnt - 8'd1;
                            end else if (r_step >= i_last) begin
                                // ">=" lets a lowered i_last end the
                                // sequence once the current step finishes.
                                if (i_loop) begin
                                    r_step    <= 2'd0;
                                    r_dur_cnt <= r_table[0][7:0];
                                    r_rgb     <= r_table[0][10:8];
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_step    <= w_next_step;
                                r_dur_cnt <= r_table[w_next_step][7:0];
                                r_rgb     <= r_table[w_next_step][10:8];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // LED register, refreshed only on strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= 3'b000;
        end else if (i_stb) begin
            r_led <= w_led_next;
        end
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;
    assign o_step = r_step;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq
//  Description : Self-checking bench for led_seq with a strobe-level
//                reference model and randomized episodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        wr;
    logic [1:0]  waddr;
    logic [10:0] wdata;
    logic [1:0]  last;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic [3:0]  bright;
    logic [2:0]  led;
    logic        busy;
    logic [1:0]  step;
    logic        done;

    always #5 clk = ~clk;

    led_seq #(
        .TICK_STB (TICK),
        .CLK_FREQ (48_000_000)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_stb    (stb),
        .i_wr     (wr),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_last   (last),
        .i_loop   (loop_en),
        .i_start  (start),
        .i_stop   (stop),
        .i_bright (bright),
        .o_led    (led),
        .o_busy   (busy),
        .o_step   (step),
        .o_done   (done)
    );

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    // Reference model: a step is simply a number of strobes to wait,
    // (dur+1)*TICK, counted down while playing.
    logic [10:0] m_tab [4];
    logic        m_play;
    logic [1:0]  m_step;
    int          m_rem;
    logic [2:0]  m_rgb;
    logic [2:0]  m_led;
    logic        m_done;
    int          m_pwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_tab[i] = 11'd0;
        m_play = 1'b0;
        m_step = 2'd0;
        m_rem  = 0;
        m_rgb  = 3'b000;
        m_led  = 3'b000;
        m_done = 1'b0;
        m_pwm  = 0;
    endtask

    task automatic model_enter(input int s);
        m_step = s[1:0];
        m_rem  = (int'(m_tab[s][7:0]) + 1) * TICK;
        m_rgb  = m_tab[s][10:8];
    endtask

    task automatic model_edge();
        logic [2:0] mask;
        if (stb) begin
            mask = 3'b111;
`ifdef LED_SEQ_PWM_EN
            if (m_pwm > int'(bright)) mask = 3'b000;
            m_pwm = (m_pwm + 1) % 16;
`endif
            m_led = m_play ? (m_rgb & mask) : 3'b000;
        end
        m_done = 1'b0;
        if (m_play) begin
            if (stop) begin
                m_play = 1'b0;
            end else if (start) begin
                model_enter(0);
            end else if (stb) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_step >= last) begin
                        if (loop_en) model_enter(0);
                        else begin
                            m_play = 1'b0;
                            m_done = 1'b1;
                        end
                    end else begin
                        model_enter(int'(m_step) + 1);
                    end
                end
            end
        end else if (start && !stop) begin
            m_play = 1'b1;
            model_enter(0);
        end
        if (wr) m_tab[waddr] = wdata;
    endtask

    // One clock: strobe every 8 clocks, advance model, sample #1 later.
    task automatic clk1();
        stb   = (phase == 0);
        phase = (phase + 1) % 8;
        @(posedge clk);
        model_edge();
        #1;
        chk("led",  32'(led),  32'(m_led));
        chk("busy", 32'(busy), 32'(m_play));
        chk("step", 32'(step), 32'(m_step));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [10:0] d);
        wr = 1'b1; waddr = a; wdata = d;
        clk1();
        wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        clk1();
        start = 1'b0;
    endtask

    initial begin
        int n_done;
        int n_red;
        int n_grn;
        int n_on;
        rst = 1'b1; stb = 1'b0; wr = 1'b0; waddr = 2'd0; wdata = 11'd0;
        last = 2'd0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; bright = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  32'(led),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // One-shot: 100 for 2 ticks, 010 for 1 tick, then done once.
        write_entry(2'd0, {3'b100, 8'd1});
        write_entry(2'd1, {3'b010, 8'd0});
        last = 2'd1; loop_en = 1'b0;
        pulse_start();
        n_done = 0; n_red = 0; n_grn = 0;
        repeat (160) begin
            clk1();
            if (done) n_done++;
            if (led == 3'b100) n_red++;
            if (led == 3'b010) n_grn++;
        end
        chk("oneshot_done_cnt", 32'(n_done), 32'd1);
        chk("oneshot_red_cyc",  32'(n_red),  32'd64);
        chk("oneshot_grn_cyc",  32'(n_grn),  32'd32);
        chk("oneshot_busy",     32'(busy),   32'd0);
        chk("oneshot_led",      32'(led),    32'd0);
        chk("oneshot_step",     32'(step),   32'd1);

        // Looping, then rewrite the live step's colour.
        loop_en = 1'b1;
        pulse_start();
        n_done = 0;
        repeat (20) begin clk1(); if (done) n_done++; end
        write_entry(2'd0, {3'b001, 8'd1});
        repeat (300) begin clk1(); if (done) n_done++; end
        chk("loop_no_done", 32'(n_done), 32'd0);

        // Start and stop together mid-play: stop wins.
        start = 1'b1; stop = 1'b1;
        clk1();
        start = 1'b0; stop = 1'b0;
        n_done = 0;
        repeat (20) begin clk1(); if (done) n_done++; end
        chk("collide_busy", 32'(busy),   32'd0);
        chk("collide_led",  32'(led),    32'd0);
        chk("collide_done", 32'(n_done), 32'd0);

        // Asynchronous reset between clock edges, mid-play.
        pulse_start();
        repeat (50) clk1();
        #2 rst = 1'b1;
        #1;
        chk("arst_led",  32'(led),  32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_step", 32'(step), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        rst = 1'b0;
        model_reset();
        pulse_start();
        n_on = 0;
        repeat (100) begin clk1(); if (led != 3'b000) n_on++; end
        chk("arst_table_zero", 32'(n_on), 32'd0);
        stop = 1'b1; clk1(); stop = 1'b0;

        // Dimming: white at brightness 3 over one full 16-strobe PWM period.
        write_entry(2'd0, {3'b111, 8'd255});
        last = 2'd0; loop_en = 1'b1; bright = 4'd3;
        pulse_start();
        repeat (24) clk1();
        n_on = 0;
        repeat (128) begin clk1(); if (led == 3'b111) n_on++; end
`ifdef LED_SEQ_PWM_EN
        chk("dim_on_cycles", 32'(n_on), 32'd32);
`else
        chk("dim_on_cycles", 32'(n_on), 32'd128);
`endif
        stop = 1'b1; clk1(); stop = 1'b0;

        // Randomized episodes against the model.
        for (int ep = 0; ep < 30; ep++) begin
            for (int a = 0; a < 4; a++) begin
                write_entry(a[1:0], {3'($urandom), 8'($urandom_range(0, 6))});
            end
            last    = 2'($urandom);
            loop_en = 1'($urandom);
            bright  = 4'($urandom);
            pulse_start();
            repeat (800) begin
                start = ($urandom_range(0, 299) == 0);
                stop  = ($urandom_range(0, 499) == 0);
                wr    = ($urandom_range(0, 39) == 0);
                waddr = 2'($urandom);
                wdata = {3'($urandom), 8'($urandom_range(0, 6))};
                if ($urandom_range(0, 199) == 0) last = 2'($urandom);
                if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
                clk1();
            end
            start = 1'b0; stop = 1'b0; wr = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_seq.md
Name: led_seq

Overview:
- RGB LED pattern sequencer for the Fomu.
- Plays a programmable table of up to 4 steps. Each step is a colour plus a duration in ticks.
- Output changes are paced by the 46.875 kHz strobe from clk_div. An optional 16-level PWM dimmer is included.
- o_led[2:0] feeds three led_freq instances, one per channel, ahead of the RGB driver. The sequencer shares the single LED among the table steps and owns its timing.

Parameters:
- TICK_STB, 469: number of i_stb strobes per duration tick (about 10 ms at 46.875 kHz); must be >= 2.
- CLK_FREQ, 48_000_000: system clock in Hz; documentation only, no logic depends on it.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_stb  in  1  46.875 kHz strobe from clk_div; one i_clk wide.
- i_wr  in  1  table write enable; accepted every cycle, never stalls.
- i_waddr  in  2  table entry index.
- i_wdata  in  11  {rgb[2:0], dur[7:0]}; the step lasts dur+1 ticks.
- i_last  in  2  index of the final step in the sequence.
- i_loop  in  1  1: wrap from step i_last to step 0; 0: one-shot.
- i_start  in  1  pulse: begin or restart playback at step 0.
- i_stop  in  1  pulse: abort playback.
- i_bright  in  4  PWM brightness level (see Optional Feature).
- o_led  out  3  {r,g,b} requested LED levels.
- o_busy  out  1  1 while in PLAY.
- o_step  out  2  current step index.
- o_done  out  1  one-cycle pulse when a one-shot sequence completes.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; o_led=0, o_busy=0, o_step=0, o_done=0.
  - All table entries cleared to 0.
  - Tick, duration and PWM counters cleared to 0.
- Reset release needs no synchronisation beyond that of the surrounding design.
- Table writes: on i_wr, entry[i_waddr] <= i_wdata at the clock edge. A write to the step currently playing takes effect only on the next entry into that step. Its remaining duration and its colour are both unaffected.
- Tick counter:
  - Active in PLAY only; counts i_stb.
  - When it equals TICK_STB-1 and i_stb=1, it wraps to 0 and raises an internal tick for that cycle.
  - Cleared on entry to PLAY.
- Duration counter (8 bit):
  - Loaded with entry.dur on step entry.
  - On each tick: if the count is nonzero, decrement; if it is 0, the step ends.
- State IDLE:
  - o_led=0, o_busy=0.
  - i_start -> PLAY with step=0; the duration counter is loaded from entry[0].
- State PLAY:
  - o_busy=1.
  - Step end with step != i_last: step+1.
  - Step end with step == i_last and i_loop=1: step 0.
  - Step end with step == i_last and i_loop=0: -> IDLE; o_done=1 for one cycle; o_step holds i_last.
  - i_stop -> IDLE next cycle, o_done stays 0.
  - i_start -> restart at step 0, tick counter cleared.
- Simultaneous events:
  - i_start and i_stop in the same cycle: i_stop wins.
  - i_start in the same cycle as a one-shot completion: the restart wins and o_done is 0.
- i_last lowered below the current step: the current step finishes, then the step>=i_last comparison ends or wraps the sequence.
- Output timing:
  - o_led is registered and updates only in the cycle after an i_stb. It never changes between strobes.
  - In PLAY, o_led = entry[step].rgb gated by the PWM term.
  - Leaving PLAY forces o_led to 0 at the next strobe update.
  - Latency from step change to o_led: at most 1 strobe period + 1 clock.

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- Defined:
  - A 4-bit PWM counter is free-running and increments on every i_stb in all states, wrapping 15->0.
  - Each set rgb bit drives o_led=1 only when pwm_cnt <= i_bright: 0 gives 1/16 duty, 15 gives full on.
  - i_bright is sampled with each strobe.
- Not defined:
  - No PWM counter; i_bright is ignored (port kept).
  - o_led = entry[step].rgb at full duty, still strobe-aligned.

Test Plan (TICK_STB=4, i_stb every 8 clocks):
- Reset and table: write entry0={3'b100,8'd1}, entry1={3'b010,8'd0}; i_last=1, i_loop=0; pulse i_start -> o_led=100 for 2 ticks (8 strobes), then 010 for 1 tick, then o_done pulses once; o_busy=0, o_led=000.
- Loop: same table with i_loop=1 -> o_step sequence 0,0,1,0,0,1... per tick; o_done never asserts.
- Stop and start collision: assert i_start and i_stop together mid-PLAY -> IDLE, o_led=0 at the next strobe, o_done=0.
- Write to the live step: rewrite entry0 rgb to 001 while step 0 plays -> current step still shows 100; the next loop pass shows 001.
- Async reset mid-PLAY: pulse i_rst between clock edges -> outputs 0 immediately; table reads all-zero afterwards (a restart shows o_led=000).
- Dimming (LED_SEQ_PWM_EN): i_bright=3, rgb=111 -> each channel high for 4 of every 16 strobes.
- Dimming off (LED_SEQ_PWM_EN undefined): same stimulus -> o_led=111 steadily.
